// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// State encoding is visible on state_o, so the values are fixed.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [7:0] CNT_SAT = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Clears to 0 so a PLL that was locked before reset is not trusted.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, waits for lock with timeout/retry, qualifies lock, then
// releases ready_o; any loss of lock or soft reset restarts the sequence.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       soft_reset_i,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       ready_o,
  output logic [1:0] state_o,
  output logic [7:0] retry_cnt_o,
  output logic [7:0] lol_cnt_o,
  output logic       fail_o
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

  logic             lock_s;
  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       retry_reg, retry_next;
  logic [7:0]       lol_reg, lol_next;
  logic             fail_reg, fail_next;
  logic             pll_rst_reg;
  logic             ready_reg;
  logic             parked;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked_i),
    .q     (lock_s)
  );

  // Retries only reach the limit on the final timeout; soft reset clears them.
  assign parked = (retry_reg == RETRY_MAX);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_ONE;
    retry_next = retry_reg;
    lol_next   = lol_reg;
    fail_next  = fail_reg;
    if (soft_reset_i) begin
      state_next = RST_PLL;
      cnt_next   = '0;
      retry_next = '0;
    end else begin
      case (state_reg)
        RST_PLL: begin
          if (cnt_reg == RST_TC) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        WAIT_LOCK: begin
          if (parked) begin
            cnt_next = '0;
          end else if (lock_s) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == LOCK_TC) begin
            cnt_next   = '0;
            retry_next = retry_reg + 8'd1;
            if (retry_reg + 8'd1 == RETRY_MAX) begin
              fail_next = 1'b1;
            end else begin
              state_next = RST_PLL;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_TC) begin
            state_next = RUN;
            cnt_next   = '0;
            retry_next = '0;
          end
        end
        default: begin
          cnt_next = '0;
          if (!lock_s) begin
            state_next = RST_PLL;
            if (lol_reg != CNT_SAT) lol_next = lol_reg + 8'd1;
          end
        end
      endcase
    end
  end

  // Output flops decode the next state so they line up with state_o.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RST_PLL;
      cnt_reg     <= '0;
      retry_reg   <= '0;
      lol_reg     <= '0;
      fail_reg    <= 1'b0;
      pll_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      lol_reg     <= lol_next;
      fail_reg    <= fail_next;
      pll_rst_reg <= (state_next == RST_PLL);
      ready_reg   <= (state_next == RUN);
    end
  end

  assign pll_rst_o   = pll_rst_reg;
  assign ready_o     = ready_reg;
  assign state_o     = state_reg;
  assign retry_cnt_o = retry_reg;
  assign lol_cnt_o   = lol_reg;
  assign fail_o      = fail_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       soft_reset_i;
  logic       pll_locked_i;
  logic       pll_rst_o;
  logic       ready_o;
  logic [1:0] state_o;
  logic [7:0] retry_cnt_o;
  logic [7:0] lol_cnt_o;
  logic       fail_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .soft_reset_i (soft_reset_i),
    .pll_locked_i (pll_locked_i),
    .pll_rst_o    (pll_rst_o),
    .ready_o      (ready_o),
    .state_o      (state_o),
    .retry_cnt_o  (retry_cnt_o),
    .lol_cnt_o    (lol_cnt_o),
    .fail_o       (fail_o)
  );

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; soft_reset_i = 1'b0; pll_locked_i = 1'b0;
    step(3);
    n_cmp++; if (pll_rst_o !== 1'b1) begin n_bad++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if ({retry_cnt_o, lol_cnt_o, fail_o} !== 17'd0) begin n_bad++; $display("FAIL reset_status: retry %0d lol %0d fail %b want 0/0/0", retry_cnt_o, lol_cnt_o, fail_o); end
    rst_n = 1'b1;
    n = 0;
    while (pll_rst_o && n < 50) begin n++; step(); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL release_pll_rst_width: got %0d want 4", n); end
    n_cmp++; if (state_o !== 2'd1) begin n_bad++; $display("FAIL release_wait_state: got %0d want 1", state_o); end
    $display("reset: pll_rst width %0d cycles after release", n);
  endtask

  task automatic test_first_lock();
    int n;
    step(9);
    n_cmp++; if (state_o !== 2'd1) begin n_bad++; $display("FAIL first_lock_waiting: got %0d want 1", state_o); end
    pll_locked_i = 1'b1;
    n = 0;
    while (!ready_o && n < 50) begin step(); n++; end
    n_cmp++; if (n !== 11) begin n_bad++; $display("FAIL first_lock_latency: got %0d want 11", n); end
    n_cmp++; if (state_o !== 2'd3) begin n_bad++; $display("FAIL first_lock_state: got %0d want 3", state_o); end
    n_cmp++; if (retry_cnt_o !== 8'd0 || pll_rst_o !== 1'b0) begin n_bad++; $display("FAIL first_lock_status: retry %0d pll_rst %b want 0/0", retry_cnt_o, pll_rst_o); end
    $display("first_lock: ready after %0d cycles", n);
  endtask

  task automatic test_loss_of_lock();
    int n;
    for (int i = 1; i <= 2; i++) begin
      pll_locked_i = 1'b0;
      n = 0;
      while (ready_o && n < 20) begin step(); n++; end
      n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL lol_ready_fall_%0d: got %0d want 3", i, n); end
      n_cmp++; if (lol_cnt_o !== 8'(i) || state_o !== 2'd0) begin n_bad++; $display("FAIL lol_count_%0d: lol %0d state %0d want %0d/0", i, lol_cnt_o, state_o, i); end
      n = 0;
      while (pll_rst_o && n < 20) begin n++; step(); end
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL lol_pll_rst_width_%0d: got %0d want 4", i, n); end
      pll_locked_i = 1'b1;
      n = 0;
      while (!ready_o && n < 50) begin step(); n++; end
      n_cmp++; if (n !== 11) begin n_bad++; $display("FAIL lol_relock_%0d: got %0d want 11", i, n); end
      $display("loss_of_lock %0d: lol_cnt %0d relock %0d cycles", i, lol_cnt_o, n);
    end
  endtask

  task automatic test_stable_glitch();
    int n;
    pll_locked_i = 1'b0;
    n = 0;
    while (ready_o && n < 20) begin step(); n++; end
    n = 0;
    while (pll_rst_o && n < 20) begin n++; step(); end
    n = 0;
    while (state_o == 2'd1 && n < 100) begin n++; step(); end
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL timeout_length: got %0d want 32", n); end
    n_cmp++; if (retry_cnt_o !== 8'd1 || pll_rst_o !== 1'b1) begin n_bad++; $display("FAIL timeout_retry: retry %0d pll_rst %b want 1/1", retry_cnt_o, pll_rst_o); end
    n = 0;
    while (pll_rst_o && n < 20) begin n++; step(); end
    pll_locked_i = 1'b1;
    step(6);
    pll_locked_i = 1'b0;
    step();
    pll_locked_i = 1'b1;
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL glitch_in_stable: got %0d want 2", state_o); end
    step();
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL glitch_sync_delay: got %0d want 2", state_o); end
    step();
    n_cmp++; if (state_o !== 2'd1 || retry_cnt_o !== 8'd1 || ready_o !== 1'b0) begin n_bad++; $display("FAIL glitch_back_to_wait: state %0d retry %0d ready %b want 1/1/0", state_o, retry_cnt_o, ready_o); end
    n = 0;
    while (!ready_o && n < 50) begin step(); n++; end
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL glitch_fresh_run: got %0d want 9", n); end
    n_cmp++; if (retry_cnt_o !== 8'd0 || lol_cnt_o !== 8'd3) begin n_bad++; $display("FAIL glitch_run_status: retry %0d lol %0d want 0/3", retry_cnt_o, lol_cnt_o); end
    $display("stable_glitch: fresh run took %0d cycles", n);
  endtask

  task automatic test_soft_reset();
    int n;
    soft_reset_i = 1'b1;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL soft_pre_ready: got %b want 1", ready_o); end
    step();
    n_cmp++; if (ready_o !== 1'b0 || pll_rst_o !== 1'b1 || state_o !== 2'd0) begin n_bad++; $display("FAIL soft_entry: ready %b pll_rst %b state %0d want 0/1/0", ready_o, pll_rst_o, state_o); end
    step(5);
    n_cmp++; if (state_o !== 2'd0 || pll_rst_o !== 1'b1) begin n_bad++; $display("FAIL soft_hold: state %0d pll_rst %b want 0/1", state_o, pll_rst_o); end
    soft_reset_i = 1'b0;
    n = 0;
    while (pll_rst_o && n < 20) begin n++; step(); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL soft_release_width: got %0d want 4", n); end
    n = 0;
    while (!ready_o && n < 50) begin step(); n++; end
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL soft_relock: got %0d want 9", n); end
    n_cmp++; if (lol_cnt_o !== 8'd3) begin n_bad++; $display("FAIL soft_lol_unchanged: got %0d want 3", lol_cnt_o); end
    $display("soft_reset: relock %0d cycles after pll_rst fell", n);
  endtask

  task automatic test_retry_exhaust();
    int n;
    pll_locked_i = 1'b0;
    n = 0;
    while (ready_o && n < 20) begin step(); n++; end
    for (int a = 1; a <= 2; a++) begin
      n = 0;
      while (pll_rst_o && n < 20) begin n++; step(); end
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL retry_pulse_%0d: got %0d want 4", a, n); end
      n = 0;
      while (state_o == 2'd1 && n < 100) begin n++; step(); end
      n_cmp++; if (n !== 32 || retry_cnt_o !== 8'(a)) begin n_bad++; $display("FAIL retry_timeout_%0d: len %0d retry %0d want 32/%0d", a, n, retry_cnt_o, a); end
      $display("retry %0d: timeout after %0d cycles", a, n);
    end
    n = 0;
    while (pll_rst_o && n < 20) begin n++; step(); end
    n = 0;
    while (!fail_o && n < 100) begin n++; step(); end
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL fail_timeout: got %0d want 32", n); end
    n_cmp++; if (state_o !== 2'd1 || retry_cnt_o !== 8'd3 || pll_rst_o !== 1'b0 || lol_cnt_o !== 8'd4) begin n_bad++; $display("FAIL fail_status: state %0d retry %0d pll_rst %b lol %0d want 1/3/0/4", state_o, retry_cnt_o, pll_rst_o, lol_cnt_o); end
    step(40);
    n_cmp++; if (state_o !== 2'd1 || pll_rst_o !== 1'b0 || fail_o !== 1'b1) begin n_bad++; $display("FAIL fail_parked: state %0d pll_rst %b fail %b want 1/0/1", state_o, pll_rst_o, fail_o); end
    $display("retry_exhaust: fail_o=%b retry_cnt=%0d", fail_o, retry_cnt_o);
  endtask

  task automatic test_soft_in_fail();
    int n;
    soft_reset_i = 1'b1;
    step();
    soft_reset_i = 1'b0;
    n_cmp++; if (state_o !== 2'd0 || retry_cnt_o !== 8'd0 || fail_o !== 1'b1 || pll_rst_o !== 1'b1) begin n_bad++; $display("FAIL soft_fail_entry: state %0d retry %0d fail %b pll_rst %b want 0/0/1/1", state_o, retry_cnt_o, fail_o, pll_rst_o); end
    n = 0;
    while (pll_rst_o && n < 20) begin n++; step(); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL soft_fail_pulse: got %0d want 4", n); end
    step(5);
    $display("soft_in_fail: restarted, pll_rst width %0d", n);
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (pll_rst_o !== 1'b1 || ready_o !== 1'b0 || state_o !== 2'd0) begin n_bad++; $display("FAIL async_reset_ctrl: pll_rst %b ready %b state %0d want 1/0/0", pll_rst_o, ready_o, state_o); end
    n_cmp++; if ({retry_cnt_o, lol_cnt_o, fail_o} !== 17'd0) begin n_bad++; $display("FAIL async_reset_status: retry %0d lol %0d fail %b want 0/0/0", retry_cnt_o, lol_cnt_o, fail_o); end
    step(2);
    rst_n = 1'b1;
    $display("async_reset: outputs cleared without a clock edge");
  endtask

  task automatic test_lock_at_timeout();
    int n;
    n = 0;
    while (pll_rst_o && n < 20) begin n++; step(); end
    step(29);
    pll_locked_i = 1'b1;
    step(3);
    n_cmp++; if (state_o !== 2'd2 || retry_cnt_o !== 8'd0) begin n_bad++; $display("FAIL lock_beats_timeout: state %0d retry %0d want 2/0", state_o, retry_cnt_o); end
    $display("lock_at_timeout: state %0d retry %0d", state_o, retry_cnt_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_lock();
    test_loss_of_lock();
    test_stable_glitch();
    test_soft_reset();
    test_retry_exhaust();
    test_soft_in_fail();
    test_async_reset();
    test_lock_at_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
